pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and flag sequencer that drives the decode ROM's `PC` and `NZVC` inputs and consumes its combinational `address` output as the next-PC target. Each clock it advances `PC`, jumps to `address`, calls a subroutine through a small return stack, or returns from one. It also latches ALU flags and supports halt and run control. It closes the loop around the decode ROM so the ROM can be exercised as a running machine.

## Interface
- `DEPTH`, default 4: return-stack entries (2..8).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  8  jump/call target from the decode ROM, valid combinationally from current `PC`/`NZVC`.
- `jump`  in  1  load `PC` from `address`.
- `call`  in  1  push `PC+1`, then load `PC` from `address`.
- `ret`  in  1  pop the top of stack into `PC`.
- `flags_in`  in  4  new N,Z,V,C (bit 3 = N).
- `flags_we`  in  1  latch `flags_in` into `NZVC`.
- `halt_req`  in  1  request HALT.
- `run_req`  in  1  request RUN from HALT.
- `PC`  out  8  current program counter.
- `NZVC`  out  4  latched flags.
- `halted`  out  1  high in the HALT state.
- `stack_err`  out  1  sticky overflow/underflow indicator.

## Operation
- **Reset values:** `PC`=0x00, `NZVC`=0x0, state RUN, `halted`=0, `stack_err`=0, stack pointer=0 (empty). Stack contents are don't-care.
- **FSM states:** RUN and HALT.
  - RUN → HALT when `halt_req`=1. On that edge `PC`, `NZVC` and the stack do not update.
  - HALT → RUN when `run_req`=1 and `halt_req`=0. On that edge `PC` does not update.
  - If `halt_req` and `run_req` are both high, halt wins.
- **HALT:** all of `PC`, `NZVC`, stack and `stack_err` are frozen. `jump`, `call`, `ret` and `flags_we` are ignored.
- **PC priority in RUN** (one action per edge):
  - `ret` over `call` over `jump` over increment.
  - Increment: `PC` ← `PC`+1, 8-bit wrap (0xFF → 0x00).
  - `jump`: `PC` ← `address`.
  - `call`:
    - Not full: push (`PC`+1 mod 256), `PC` ← `address`.
    - Full (`DEPTH` entries): the push is discarded, `stack_err` ← 1, `PC` ← `address`, and the stack is unchanged.
  - `ret`:
    - Not empty: `PC` ← top entry, stack pointer decrements.
    - Empty: `PC` ← `PC`+1, `stack_err` ← 1.
- **Flags:** in RUN, `flags_we`=1 sets `NZVC` ← `flags_in` on the edge, independent of the PC action. Flags written on edge k are seen by the ROM from cycle k+1.
- **`stack_err`** clears only on `reset`.
- **Stack storage:** a LIFO register array indexed by a pointer of width clog2(`DEPTH`)+1.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- The ROM path `PC`/`NZVC` → `address` → sequencer is combinational within a single cycle. The next `PC` appears one edge later: a jump has 1-cycle latency.
- A `call` followed by a `ret` on the next cycle returns to call-site+1. This is 2 edges total.
- **Asynchronous reset:**
  - Asserting `reset` forces all reset values immediately, without waiting for a clock edge.
  - Reset asserted mid-call or mid-halt discards any in-flight action.
  - The first edge after deassertion performs a normal RUN action from `PC`=0x00.
- `halt_req` is level-sensitive. Holding it in HALT keeps the block halted.

## Test plan
1. **Reset and increment:** with `reset` high, `PC`=0x00 and `NZVC`=0. Release `reset` and leave all controls low for 3 edges → `PC` = 0x01, 0x02, 0x03. Force `PC` to 0xFE and let it run → 0xFF, then 0x00.
2. **Jump and flags:** at `PC`=0x03 with `address`=0x40 and `jump`=1 → `PC`=0x40 after one edge. In the same cycle drive `flags_we`=1 and `flags_in`=0xA → `NZVC`=0xA on that edge.
3. **Nested call/return:** call to 0x10 from 0x05, then call to 0x20 from 0x12. Then `ret` → `PC`=0x13, then `ret` → `PC`=0x06. `stack_err` stays 0.
4. **Overflow and underflow (`DEPTH`=4):**
   - Five consecutive calls → the fifth call still loads `address`, `stack_err`=1, and 4 returns give the first four return addresses in LIFO order.
   - A further `ret` on the empty stack → `PC` increments and `stack_err` stays 1.
5. **Halt and run:**
   - `halt_req` at `PC`=0x08 together with `jump` and `address`=0x50 → `PC` stays 0x08 and `halted`=1.
   - `jump`, `flags_we` and `call` during HALT have no effect.
   - `run_req` → `halted`=0 with `PC` still 0x08. The next edge gives 0x09.
6. **Simultaneous controls and async reset:**
   - `ret`+`call`+`jump` together with a non-empty stack → the pop wins.
   - Assert `reset` between clock edges during a `call` → `PC`=0x00, the stack is empty, `stack_err`=0 immediately, and no push is recorded.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Control/status bundle between the decode ROM side and the
//                program-counter sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  logic [7:0] address;
  logic       jump;
  logic       call;
  logic       ret;
  logic [3:0] flags_in;
  logic       flags_we;
  logic       halt_req;
  logic       run_req;
  logic [7:0] PC;
  logic [3:0] NZVC;
  logic       halted;
  logic       stack_err;

  // ROM / controller side: drives controls, observes sequencer state
  modport master (
    output address, jump, call, ret, flags_in, flags_we, halt_req, run_req,
    input  PC, NZVC, halted, stack_err
  );

  // Sequencer side
  modport slave (
    input  address, jump, call, ret, flags_in, flags_we, halt_req, run_req,
    output PC, NZVC, halted, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter / flag sequencer with a small return stack
//                and RUN/HALT control, closing the loop around a decode ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]    r_state;
  logic [7:0]    r_pc;
  logic [3:0]    r_nzvc;
  logic          r_err;
  logic [PW-1:0] r_sp;
  logic [7:0]    r_stack [DEPTH];

  logic          w_active;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic [7:0]    w_pc_inc;
  logic [PW-1:0] w_sp_dec;
  logic [PW-2:0] w_wr_idx;
  logic [PW-2:0] w_rd_idx;

  // An edge acts on PC/flags/stack only in RUN with no halt request pending
  assign w_active = (r_state == ST_RUN) && !bus.halt_req;
  assign w_full   = (r_sp == PW'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_pc_inc = r_pc + 8'd1;
  assign w_sp_dec = r_sp - PW'(1);
  assign w_wr_idx = r_sp[PW-2:0];
  assign w_rd_idx = w_sp_dec[PW-2:0];
  // ret outranks call, so a push happens only for a lone (non-ret) call
  assign w_push   = w_active && !bus.ret && bus.call && !w_full;

  // RUN/HALT control; halt wins over run when both are requested
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (bus.halt_req) r_state <= ST_HALT;
    end else begin
      if (bus.run_req && !bus.halt_req) r_state <= ST_RUN;
    end
  end

  // PC, stack pointer and sticky error: ret > call > jump > increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc  <= 8'h00;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else if (w_active) begin
      if (bus.ret) begin
        if (w_empty) begin
          r_pc  <= w_pc_inc;
          r_err <= 1'b1;
        end else begin
          r_pc <= r_stack[w_rd_idx];
          r_sp <= w_sp_dec;
        end
      end else if (bus.call) begin
        r_pc <= bus.address;
        if (w_full) r_err <= 1'b1;
        else        r_sp  <= r_sp + PW'(1);
      end else if (bus.jump) begin
        r_pc <= bus.address;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  // Flag latch, independent of the PC action
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nzvc <= 4'h0;
    end else if (w_active && bus.flags_we) begin
      r_nzvc <= bus.flags_in;
    end
  end

  // Return-stack storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (w_push) r_stack[w_wr_idx] <= w_pc_inc;
  end

  assign bus.PC        = r_pc;
  assign bus.NZVC      = r_nzvc;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.stack_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if bus ();

  pc_sequencer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [3:0] m_nzvc;
  logic       m_halted;
  logic       m_err;
  logic [7:0] m_stack [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 8'h00;
    m_nzvc   = 4'h0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_stack.delete();
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (!reset) begin
      check("pc",        bus.PC,        m_pc);
      check("nzvc",      bus.NZVC,      m_nzvc);
      check("halted",    bus.halted,    m_halted);
      check("stack_err", bus.stack_err, m_err);
    end
  end

  // Advance one edge: compute the model's next state from the architectural
  // rules, take the edge, then commit. Returns just after the falling edge.
  task automatic tick();
    logic [7:0] n_pc;
    logic [3:0] n_nzvc;
    logic       n_halted;
    logic       n_err;
    logic [7:0] n_stack [$];
    n_pc     = m_pc;
    n_nzvc   = m_nzvc;
    n_halted = m_halted;
    n_err    = m_err;
    n_stack  = m_stack;
    if (m_halted) begin
      if (bus.run_req && !bus.halt_req) n_halted = 1'b0;
    end else if (bus.halt_req) begin
      n_halted = 1'b1;
    end else begin
      if (bus.ret) begin
        if (n_stack.size() == 0) begin
          n_pc  = 8'((int'(m_pc) + 1) % 256);
          n_err = 1'b1;
        end else begin
          n_pc = n_stack.pop_back();
        end
      end else if (bus.call) begin
        if (n_stack.size() == DEPTH) n_err = 1'b1;
        else n_stack.push_back(8'((int'(m_pc) + 1) % 256));
        n_pc = bus.address;
      end else if (bus.jump) begin
        n_pc = bus.address;
      end else begin
        n_pc = 8'((int'(m_pc) + 1) % 256);
      end
      if (bus.flags_we) n_nzvc = bus.flags_in;
    end
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      m_pc     = n_pc;
      m_nzvc   = n_nzvc;
      m_halted = n_halted;
      m_err    = n_err;
      m_stack  = n_stack;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    bus.jump     = 1'b0;
    bus.call     = 1'b0;
    bus.ret      = 1'b0;
    bus.flags_we = 1'b0;
    bus.halt_req = 1'b0;
    bus.run_req  = 1'b0;
  endtask

  // Hand-computed expectation checked against both the DUT and the model
  task automatic pin_pc(input string name, input logic [7:0] exp);
    check(name, bus.PC, exp);
    check({name, "_model"}, m_pc, exp);
  endtask

  // Assert reset between edges, check it took effect at once, release later
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_pc",  bus.PC, 8'h00);
    check("rst_err", bus.stack_err, 1'b0);
    check("rst_hlt", bus.halted, 1'b0);
    check("rst_nz",  bus.NZVC, 4'h0);
    @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic do_jump(input logic [7:0] a);
    idle(); bus.jump = 1'b1; bus.address = a; tick(); idle();
  endtask

  task automatic do_call(input logic [7:0] a);
    idle(); bus.call = 1'b1; bus.address = a; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret = 1'b1; tick(); idle();
  endtask

  initial begin
    idle();
    bus.address  = 8'h00;
    bus.flags_in = 4'h0;
    model_reset();

    // 1. reset values and increment with wrap
    #3;
    check("reset_pc",   bus.PC, 8'h00);
    check("reset_nzvc", bus.NZVC, 4'h0);
    @(negedge clock);
    #2 reset = 1'b0;
    tick(); pin_pc("inc1", 8'h01);
    tick(); pin_pc("inc2", 8'h02);
    tick(); pin_pc("inc3", 8'h03);
    do_jump(8'hFE);
    tick(); pin_pc("wrap_ff", 8'hFF);
    tick(); pin_pc("wrap_00", 8'h00);

    // 2. jump and flag write on the same edge
    tick(); tick(); tick();
    pin_pc("at_03", 8'h03);
    bus.jump = 1'b1; bus.address = 8'h40; bus.flags_we = 1'b1; bus.flags_in = 4'hA;
    tick(); idle();
    pin_pc("jump_40", 8'h40);
    check("flags_a", bus.NZVC, 4'hA);

    // 3. nested call/return
    do_jump(8'h05);
    do_call(8'h10);
    tick(); tick();
    pin_pc("at_12", 8'h12);
    do_call(8'h20);
    do_ret(); pin_pc("ret_13", 8'h13);
    do_ret(); pin_pc("ret_06", 8'h06);
    check("nest_err", bus.stack_err, 1'b0);

    // 4. overflow then underflow
    do_call(8'h30); do_call(8'h31); do_call(8'h32); do_call(8'h33);
    check("four_err", bus.stack_err, 1'b0);
    do_call(8'h34);
    pin_pc("ovf_pc", 8'h34);
    check("ovf_err", bus.stack_err, 1'b1);
    do_ret(); pin_pc("lifo_33", 8'h33);
    do_ret(); pin_pc("lifo_32", 8'h32);
    do_ret(); pin_pc("lifo_31", 8'h31);
    do_ret(); pin_pc("lifo_07", 8'h07);
    do_ret(); pin_pc("udf_pc", 8'h08);
    check("udf_err", bus.stack_err, 1'b1);

    // 5. halt and run
    bus.halt_req = 1'b1; bus.jump = 1'b1; bus.address = 8'h50;
    tick(); idle();
    pin_pc("halt_pc", 8'h08);
    check("halt_flag", bus.halted, 1'b1);
    bus.jump = 1'b1; bus.address = 8'h55; tick(); idle();
    bus.flags_we = 1'b1; bus.flags_in = 4'h5; tick(); idle();
    bus.call = 1'b1; bus.address = 8'h66; tick(); idle();
    pin_pc("halt_frozen", 8'h08);
    check("halt_nzvc", bus.NZVC, 4'hA);
    bus.run_req = 1'b1; bus.halt_req = 1'b1; tick(); idle();
    check("halt_wins", bus.halted, 1'b1);
    bus.run_req = 1'b1; tick(); idle();
    check("run_flag", bus.halted, 1'b0);
    pin_pc("run_pc", 8'h08);
    tick(); pin_pc("run_next", 8'h09);

    // 6. ret wins over call/jump; async reset during a call
    do_call(8'h60);
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.address = 8'h70;
    tick(); idle();
    pin_pc("pop_wins", 8'h0A);
    bus.call = 1'b1; bus.address = 8'h77;
    async_reset();
    idle();
    do_ret();
    pin_pc("empty_after_rst", 8'h01);
    check("empty_err", bus.stack_err, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.address  = 8'($urandom);
      bus.flags_in = 4'($urandom);
      bus.jump     = ($urandom % 4) == 0;
      bus.call     = ($urandom % 5) == 0;
      bus.ret      = ($urandom % 5) == 0;
      bus.flags_we = ($urandom % 3) == 0;
      bus.halt_req = ($urandom % 12) == 0;
      bus.run_req  = ($urandom % 3) == 0;
      if (($urandom % 150) == 0) async_reset();
      else tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
